beu_clmul_seq: RTL and testbench



---
 rtl/beu_clmul_seq_pkg.sv | 27 ++
 rtl/beu_clmul_seq_if.sv | 24 ++
 rtl/beu_clmul_seq_step.sv | 21 ++
 rtl/beu_clmul_seq.sv | 95 +++++++++
 tb/tb_beu_clmul_seq.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/beu_clmul_seq_pkg.sv
// Shared types for the carry-less multiply sequencer: function codes,
// FSM state encoding and the product-slice selection helper.
package p_hardisc;

  typedef enum logic [1:0] {
    CLMUL_LO   = 2'b00,
    CLMUL_HI   = 2'b01,
    CLMUL_REV  = 2'b10,
    CLMUL_RSVD = 2'b11
  } clmul_fn;

  typedef logic [1:0] clmul_state;
  localparam clmul_state IDLE = 2'd0;
  localparam clmul_state RUN  = 2'd1;
  localparam clmul_state DONE = 2'd2;

  // The reserved code still runs the full latency but yields zero.
  function automatic logic [31:0] select_result(input logic [63:0] product, input clmul_fn fn);
    case (fn)
      CLMUL_LO:  return product[31:0];
      CLMUL_HI:  return product[63:32];
      CLMUL_REV: return product[62:31];
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/beu_clmul_seq_if.sv
// Issue/result handshake between the execute stage and the clmul sequencer.
interface beu_clmul_seq_if;

  logic        s_start_i;
  logic [1:0]  s_function_i;
  logic [31:0] s_op1_i;
  logic [31:0] s_op2_i;
  logic        s_flush_i;
  logic        s_ack_i;
  logic        s_busy_o;
  logic        s_valid_o;
  logic [31:0] s_result_o;

  modport master (
    output s_start_i, s_function_i, s_op1_i, s_op2_i, s_flush_i, s_ack_i,
    input  s_busy_o, s_valid_o, s_result_o
  );

  modport slave (
    input  s_start_i, s_function_i, s_op1_i, s_op2_i, s_flush_i, s_ack_i,
    output s_busy_o, s_valid_o, s_result_o
  );

endinterface

// File: rtl/beu_clmul_seq_step.sv
// One RUN step: XOR of op1 shifted by every set bit of a multiplier slice
// that starts at bit position 'offset'.
module clmul_step #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic [31:0]               op1,
  input  logic [BITS_PER_CYCLE-1:0] slice,
  input  logic [4:0]                offset,
  output logic [63:0]               partial
);

  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (slice[j]) begin
        partial = partial ^ ({32'b0, op1} << (6'(offset) + 6'(j)));
      end
    end
  end

endmodule

// File: rtl/beu_clmul_seq.sv
// Multi-cycle carry-less multiplier (clmul/clmulh/clmulr) that consumes
// BITS_PER_CYCLE multiplier bits per clock and holds its result until acked.
module beu_clmul_seq
  import p_hardisc::*;
#(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic           s_clk_i,
  input  logic           s_resetn_i,
  beu_clmul_seq_if.slave s_bus
);

  localparam int STEPS = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  clmul_state       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      op1_q;
  logic [31:0]      op2_q;
  clmul_fn          fn_q;
  logic [63:0]      acc;

  logic [4:0]                bit_off;
  logic [BITS_PER_CYCLE-1:0] slice;
  logic [63:0]               partial;

  assign bit_off = 5'(int'(cnt) * BITS_PER_CYCLE);
  assign slice   = BITS_PER_CYCLE'(op2_q >> bit_off);

  clmul_step #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .op1     (op1_q),
    .slice   (slice),
    .offset  (bit_off),
    .partial (partial)
  );

  // Flush outranks everything; DONE can re-issue directly when ack and start coincide.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state <= IDLE;
      cnt   <= '0;
      op1_q <= '0;
      op2_q <= '0;
      fn_q  <= CLMUL_LO;
      acc   <= '0;
    end else if (s_bus.s_flush_i) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_bus.s_start_i) begin
            op1_q <= s_bus.s_op1_i;
            op2_q <= s_bus.s_op2_i;
            fn_q  <= clmul_fn'(s_bus.s_function_i);
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc ^ partial;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (s_bus.s_ack_i) begin
            if (s_bus.s_start_i) begin
              op1_q <= s_bus.s_op1_i;
              op2_q <= s_bus.s_op2_i;
              fn_q  <= clmul_fn'(s_bus.s_function_i);
              acc   <= '0;
              cnt   <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_bus.s_busy_o   = (state == RUN) || (state == DONE);
  assign s_bus.s_valid_o  = (state == DONE);
  assign s_bus.s_result_o = (state == DONE) ? select_result(acc, fn_q) : '0;

endmodule

// File: tb/tb_beu_clmul_seq.sv
// Self-checking bench: three sequencers (B=1,4,8) share one stimulus stream and
// are compared every cycle against a per-instance behavioural model.
module tb_beu_clmul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  fn = 2'b00;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  beu_clmul_seq_if bus1();
  beu_clmul_seq_if bus4();
  beu_clmul_seq_if bus8();

  assign bus1.s_start_i = start; assign bus1.s_function_i = fn; assign bus1.s_op1_i = op1;
  assign bus1.s_op2_i = op2;     assign bus1.s_flush_i = flush;  assign bus1.s_ack_i = ack;
  assign bus4.s_start_i = start; assign bus4.s_function_i = fn; assign bus4.s_op1_i = op1;
  assign bus4.s_op2_i = op2;     assign bus4.s_flush_i = flush;  assign bus4.s_ack_i = ack;
  assign bus8.s_start_i = start; assign bus8.s_function_i = fn; assign bus8.s_op1_i = op1;
  assign bus8.s_op2_i = op2;     assign bus8.s_flush_i = flush;  assign bus8.s_ack_i = ack;

  beu_clmul_seq #(.BITS_PER_CYCLE(1)) dut1 (.s_clk_i(clk), .s_resetn_i(rst_n), .s_bus(bus1.slave));
  beu_clmul_seq #(.BITS_PER_CYCLE(4)) dut4 (.s_clk_i(clk), .s_resetn_i(rst_n), .s_bus(bus4.slave));
  beu_clmul_seq #(.BITS_PER_CYCLE(8)) dut8 (.s_clk_i(clk), .s_resetn_i(rst_n), .s_bus(bus8.slave));

  // Index 0 is B=1, index 1 is B=4, index 2 is B=8.
  logic        busy_a[3];
  logic        valid_a[3];
  logic [31:0] res_a[3];
  assign busy_a[0] = bus1.s_busy_o;  assign valid_a[0] = bus1.s_valid_o;  assign res_a[0] = bus1.s_result_o;
  assign busy_a[1] = bus4.s_busy_o;  assign valid_a[1] = bus4.s_valid_o;  assign res_a[1] = bus4.s_result_o;
  assign busy_a[2] = bus8.s_busy_o;  assign valid_a[2] = bus8.s_valid_o;  assign res_a[2] = bus8.s_result_o;

  int    steps_a[3] = '{32, 8, 4};
  string lbl[3]     = '{"b1", "b4", "b8"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  function automatic logic [31:0] expect_result(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) if (b[i]) p = p ^ (64'(a) << i);
    case (f)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return p[62:31];
      default: return 32'h0;
    endcase
  endfunction

  // Model: busy/valid flags, a remaining-step countdown and the pending answer.
  bit          m_busy[3];
  bit          m_valid[3];
  int          m_left[3];
  logic [31:0] m_pend[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_busy[k] = 0; m_valid[k] = 0; m_left[k] = 0; m_pend[k] = '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (flush) begin
          m_busy[k] = 0; m_valid[k] = 0;
        end else if (!m_busy[k]) begin
          if (start) begin
            m_busy[k] = 1; m_left[k] = steps_a[k]; m_pend[k] = expect_result(op1, op2, fn);
          end
        end else if (!m_valid[k]) begin
          m_left[k]--;
          if (m_left[k] == 0) m_valid[k] = 1;
        end else if (ack) begin
          if (start) begin
            m_valid[k] = 0; m_left[k] = steps_a[k]; m_pend[k] = expect_result(op1, op2, fn);
          end else begin
            m_busy[k] = 0; m_valid[k] = 0;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      check({"busy_", lbl[k]},   32'(busy_a[k]),  32'(m_busy[k]));
      check({"valid_", lbl[k]},  32'(valid_a[k]), 32'(m_valid[k]));
      check({"result_", lbl[k]}, res_a[k],        m_valid[k] ? m_pend[k] : 32'h0);
    end
  end

  // Acks until every instance is back in IDLE.
  task automatic drain();
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b1;
    for (int i = 0; i < 60 && (busy_a[0] || busy_a[1] || busy_a[2]); i++) @(negedge clk);
    ack = 1'b0;
    check("drain_idle", 32'(busy_a[0] | busy_a[1] | busy_a[2]), 32'h0);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                               input logic [31:0] exp, input string name);
    int lat;
    drain();
    @(negedge clk);
    start = 1'b1; op1 = a; op2 = b; fn = f;
    lat = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end while (!valid_a[1] && lat < 60);
    check({name, "_latency"}, 32'(lat), 32'd9);
    check({name, "_result"}, res_a[1], exp);
  endtask

  initial begin
    int lat;
    int vhigh;
    int first_lat[3];
    logic [31:0] first_res[3];

    repeat (2) @(negedge clk);
    check("reset_busy",   32'(busy_a[1]),  32'h0);
    check("reset_valid",  32'(valid_a[1]), 32'h0);
    check("reset_result", res_a[1],        32'h0);
    rst_n = 1'b1;

    applyStimulus(32'h3, 32'h3, 2'b00, 32'h00000005, "basic_lo");

    // Result held while ack stays low, then ack+start re-issues with no IDLE bubble.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("held_result", res_a[1], 32'h00000005);
      check("held_valid",  32'(valid_a[1]), 32'h1);
    end
    @(negedge clk);
    ack = 1'b1; start = 1'b1; op1 = 32'h1; op2 = 32'hDEADBEEF; fn = 2'b00;
    @(posedge clk); #1;
    ack = 1'b0; start = 1'b0;
    check("b2b_no_idle", 32'(busy_a[1]), 32'h1);
    lat = 1;
    while (!valid_a[1] && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_latency", 32'(lat), 32'd9);
    check("b2b_result",  res_a[1], 32'hDEADBEEF);

    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h55555555, "ones_lo");
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'h55555555, "ones_hi");
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hAAAAAAAA, "ones_rev");
    applyStimulus(32'h80000000, 32'h80000000, 2'b01, 32'h40000000, "top_hi");
    applyStimulus(32'h80000000, 32'h80000000, 2'b10, 32'h80000000, "top_rev");
    applyStimulus(32'h80000000, 32'h80000000, 2'b00, 32'h00000000, "top_lo");

    // Flush sampled at the end of the third RUN cycle.
    drain();
    @(negedge clk);
    start = 1'b1; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF; fn = 2'b00;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    check("flush_busy",  32'(busy_a[1]),  32'h0);
    check("flush_valid", 32'(valid_a[1]), 32'h0);
    @(negedge clk); flush = 1'b0;
    vhigh = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid_a[1]) vhigh++;
    end
    check("flush_no_valid", 32'(vhigh), 32'h0);
    applyStimulus(32'h3, 32'h3, 2'b00, 32'h00000005, "after_flush");

    // Asynchronous reset in the middle of RUN clears outputs without a clock edge.
    drain();
    @(negedge clk);
    start = 1'b1; op1 = 32'h3; op2 = 32'h3; fn = 2'b00;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check({"async_rst_busy_", lbl[k]},   32'(busy_a[k]),  32'h0);
      check({"async_rst_valid_", lbl[k]},  32'(valid_a[k]), 32'h0);
      check({"async_rst_result_", lbl[k]}, res_a[k],        32'h0);
    end
    @(negedge clk); rst_n = 1'b1;

    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'h00000000, "reserved");

    // Latency of each width on the same operation.
    drain();
    @(negedge clk);
    start = 1'b1; op1 = 32'h3; op2 = 32'h3; fn = 2'b00;
    for (int k = 0; k < 3; k++) begin
      first_lat[k] = 0; first_res[k] = '0;
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (valid_a[k] && first_lat[k] == 0) begin
          first_lat[k] = c; first_res[k] = res_a[k];
        end
      end
    end
    check("latency_b1", 32'(first_lat[0]), 32'd33);
    check("latency_b4", 32'(first_lat[1]), 32'd9);
    check("latency_b8", 32'(first_lat[2]), 32'd5);
    check("result_lat_b1", first_res[0], 32'h00000005);
    check("result_lat_b8", first_res[2], 32'h00000005);

    drain();
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
